// File: rtl/axi_lite_master_slave_pair.sv
// Single-beat AXI4-Lite master tied to a word-addressed register-file slave.
// The user side launches one write or one read and receives a one-cycle ready pulse on completion.

module axi_lite_pair_master (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_req_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  wr_strb_i,
    input  logic        rd_req_i,
    input  logic [31:0] rd_addr_i,
    output logic        done_o,
    output logic [31:0] rd_data_o,
    output logic [1:0]  resp_o,
    output logic        busy_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [31:0] awaddr_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    input  logic        bvalid_i,
    output logic        bready_o,
    input  logic [1:0]  bresp_i,
    output logic        arvalid_o,
    input  logic        arready_i,
    output logic [31:0] araddr_o,
    input  logic        rvalid_i,
    output logic        rready_o,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4
    } state_e;

    state_e      state_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic        done_q;
    logic        busy_q;
    logic [31:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] araddr_q;
    logic [31:0] rd_data_q;
    logic [1:0]  resp_q;

    logic aw_hs_s;
    logic w_hs_s;
    logic b_hs_s;
    logic ar_hs_s;
    logic r_hs_s;
    logic aw_fin_s;
    logic w_fin_s;

    assign aw_hs_s  = awvalid_q & awready_i;
    assign w_hs_s   = wvalid_q & wready_i;
    assign b_hs_s   = bvalid_i & bready_q;
    assign ar_hs_s  = arvalid_q & arready_i;
    assign r_hs_s   = rvalid_i & rready_q;
    assign aw_fin_s = aw_done_q | aw_hs_s;
    assign w_fin_s  = w_done_q | w_hs_s;

    // Master FSM; VALIDs rise one cycle after acceptance and drop only on their own handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            awaddr_q  <= 32'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            araddr_q  <= 32'h0;
            rd_data_q <= 32'h0;
            resp_q    <= 2'b00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    if (wr_req_i) begin
                        awaddr_q <= wr_addr_i;
                        wdata_q  <= wr_data_i;
                        wstrb_q  <= wr_strb_i;
                        busy_q   <= 1'b1;
                        state_q  <= ST_WR_REQ;
                    end else if (rd_req_i) begin
                        araddr_q <= rd_addr_i;
                        busy_q   <= 1'b1;
                        state_q  <= ST_RD_REQ;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    if (aw_hs_s) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end else begin
                        awvalid_q <= ~aw_done_q;
                    end
                    if (w_hs_s) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end else begin
                        wvalid_q <= ~w_done_q;
                    end
                    if (aw_fin_s && w_fin_s) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end else begin
                        state_q <= ST_WR_REQ;
                    end
                end
                ST_WR_RESP: begin
                    if (b_hs_s) begin
                        resp_q   <= bresp_i;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        bready_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        state_q <= ST_WR_RESP;
                    end
                end
                ST_RD_REQ: begin
                    if (ar_hs_s) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_RESP;
                    end else begin
                        arvalid_q <= 1'b1;
                        state_q   <= ST_RD_REQ;
                    end
                end
                ST_RD_RESP: begin
                    if (r_hs_s) begin
                        rd_data_q <= rdata_i;
                        resp_q    <= rresp_i;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        rready_q  <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        state_q <= ST_RD_RESP;
                    end
                end
                default: begin
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    bready_q  <= 1'b0;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign done_o    = done_q;
    assign rd_data_o = rd_data_q;
    assign resp_o    = resp_q;
    assign busy_o    = busy_q;
    assign awvalid_o = awvalid_q;
    assign awaddr_o  = awaddr_q;
    assign wvalid_o  = wvalid_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;
    assign bready_o  = bready_q;
    assign arvalid_o = arvalid_q;
    assign araddr_o  = araddr_q;
    assign rready_o  = rready_q;

endmodule

module axi_lite_pair_slave #(
    parameter int DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] awaddr_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic        bvalid_o,
    input  logic        bready_i,
    output logic [1:0]  bresp_o,
    input  logic        arvalid_i,
    output logic        arready_o,
    input  logic [31:0] araddr_i,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o
);

    localparam int          IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_SERR = 2'b10;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_w[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0] mem_q [DEPTH];
    logic        awready_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    logic          wr_hs_s;
    logic          rd_hs_s;
    logic          wr_in_range_s;
    logic          rd_in_range_s;
    logic [IW-1:0] wr_idx_s;
    logic [IW-1:0] rd_idx_s;

    assign wr_hs_s       = awvalid_i & wvalid_i & awready_q;
    assign rd_hs_s       = arvalid_i & arready_q;
    assign wr_in_range_s = (awaddr_i < 32'(DEPTH));
    assign rd_in_range_s = (araddr_i < 32'(DEPTH));
    assign wr_idx_s      = awaddr_i[IW-1:0];
    assign rd_idx_s      = araddr_i[IW-1:0];

    // Write path: AWREADY/WREADY are a single shared pulse, blocked while a B response is outstanding
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            awready_q <= awvalid_i & wvalid_i & ~bvalid_q & ~awready_q;
            if (wr_hs_s) begin
                if (wr_in_range_s) begin
                    mem_q[wr_idx_s] <= merge_bytes(mem_q[wr_idx_s], wdata_i, wstrb_i);
                    bresp_q         <= RESP_OKAY;
                end else begin
                    bresp_q <= RESP_SERR;
                end
                bvalid_q <= 1'b1;
            end else if (bvalid_q && bready_i) begin
                bvalid_q <= 1'b0;
            end else begin
                bvalid_q <= bvalid_q;
            end
        end
    end

    // Read path: one-cycle ARREADY, data captured at the AR handshake and held until RREADY
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            rresp_q   <= RESP_OKAY;
        end else begin
            arready_q <= arvalid_i & ~rvalid_q & ~arready_q;
            if (rd_hs_s) begin
                if (rd_in_range_s) begin
                    rdata_q <= mem_q[rd_idx_s];
                    rresp_q <= RESP_OKAY;
                end else begin
                    rdata_q <= 32'h0;
                    rresp_q <= RESP_SERR;
                end
                rvalid_q <= 1'b1;
            end else if (rvalid_q && rready_i) begin
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rvalid_q;
            end
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = awready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;

endmodule

module axi_lite_master_slave_pair #(
    parameter int DEPTH = 8
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        valid,
    input  logic [31:0] aw_addr,
    input  logic [31:0] w_data,
    input  logic [3:0]  w_strb,
    input  logic        read_valid,
    input  logic [31:0] ar_addr,
    output logic        ready,
    output logic [31:0] rd_data,
    output logic [1:0]  resp,
    output logic        busy
);

    logic        aw_valid_s;
    logic        aw_ready_s;
    logic [31:0] aw_addr_s;
    logic        w_valid_s;
    logic        w_ready_s;
    logic [31:0] w_data_s;
    logic [3:0]  w_strb_s;
    logic        b_valid_s;
    logic        b_ready_s;
    logic [1:0]  b_resp_s;
    logic        ar_valid_s;
    logic        ar_ready_s;
    logic [31:0] ar_addr_s;
    logic        r_valid_s;
    logic        r_ready_s;
    logic [31:0] r_data_s;
    logic [1:0]  r_resp_s;

    axi_lite_pair_master u_master (
        .clk_i     (ACLK),
        .rst_ni    (ARESET),
        .wr_req_i  (valid),
        .wr_addr_i (aw_addr),
        .wr_data_i (w_data),
        .wr_strb_i (w_strb),
        .rd_req_i  (read_valid),
        .rd_addr_i (ar_addr),
        .done_o    (ready),
        .rd_data_o (rd_data),
        .resp_o    (resp),
        .busy_o    (busy),
        .awvalid_o (aw_valid_s),
        .awready_i (aw_ready_s),
        .awaddr_o  (aw_addr_s),
        .wvalid_o  (w_valid_s),
        .wready_i  (w_ready_s),
        .wdata_o   (w_data_s),
        .wstrb_o   (w_strb_s),
        .bvalid_i  (b_valid_s),
        .bready_o  (b_ready_s),
        .bresp_i   (b_resp_s),
        .arvalid_o (ar_valid_s),
        .arready_i (ar_ready_s),
        .araddr_o  (ar_addr_s),
        .rvalid_i  (r_valid_s),
        .rready_o  (r_ready_s),
        .rdata_i   (r_data_s),
        .rresp_i   (r_resp_s)
    );

    axi_lite_pair_slave #(
        .DEPTH (DEPTH)
    ) u_slave (
        .clk_i     (ACLK),
        .rst_ni    (ARESET),
        .awvalid_i (aw_valid_s),
        .awready_o (aw_ready_s),
        .awaddr_i  (aw_addr_s),
        .wvalid_i  (w_valid_s),
        .wready_o  (w_ready_s),
        .wdata_i   (w_data_s),
        .wstrb_i   (w_strb_s),
        .bvalid_o  (b_valid_s),
        .bready_i  (b_ready_s),
        .bresp_o   (b_resp_s),
        .arvalid_i (ar_valid_s),
        .arready_o (ar_ready_s),
        .araddr_i  (ar_addr_s),
        .rvalid_o  (r_valid_s),
        .rready_i  (r_ready_s),
        .rdata_o   (r_data_s),
        .rresp_o   (r_resp_s)
    );

endmodule

// File: tb/tb_axi_lite_master_slave_pair.sv
// Directed plus randomized bench for axi_lite_master_slave_pair, checked against a word-array model
// and a protocol monitor on the internal AXI4-Lite link.

module tb_axi_lite_master_slave_pair;

    localparam int DEPTH = 8;

    logic        ACLK;
    logic        ARESET;
    logic        valid;
    logic [31:0] aw_addr;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        read_valid;
    logic [31:0] ar_addr;
    logic        ready;
    logic [31:0] rd_data;
    logic [1:0]  resp;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] rd_data_m;
    logic [1:0]  resp_m;

    axi_lite_master_slave_pair #(.DEPTH(DEPTH)) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .valid      (valid),
        .aw_addr    (aw_addr),
        .w_data     (w_data),
        .w_strb     (w_strb),
        .read_valid (read_valid),
        .ar_addr    (ar_addr),
        .ready      (ready),
        .rd_data    (rd_data),
        .resp       (resp),
        .busy       (busy)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        rd_data_m = 32'h0;
        resp_m    = 2'b00;
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (addr < DEPTH) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mem_m[addr][8*b +: 8] = data[8*b +: 8];
            resp_m = 2'b00;
        end else begin
            resp_m = 2'b10;
        end
    endtask

    task automatic model_read(input logic [31:0] addr);
        if (addr < DEPTH) begin
            rd_data_m = mem_m[addr];
            resp_m    = 2'b00;
        end else begin
            rd_data_m = 32'h0;
            resp_m    = 2'b10;
        end
    endtask

    task automatic start_req(input logic wr, input logic rd, input logic [31:0] waddr,
                             input logic [31:0] wdata, input logic [3:0] strb, input logic [31:0] raddr);
        @(posedge ACLK); #1;
        valid = wr; read_valid = rd;
        aw_addr = waddr; w_data = wdata; w_strb = strb; ar_addr = raddr;
        @(posedge ACLK); #1;
        valid = 1'b0; read_valid = 1'b0;
    endtask

    // Waits for ready with a cycle budget; optionally pokes both strobes while busy.
    task automatic wait_done(input string tag, input bit poke);
        int lat;
        lat = 0;
        while (lat < 12 && ready !== 1'b1) begin
            if (lat == 2) begin
                check({tag, " busy"}, {31'h0, busy}, 32'h1);
                if (poke) begin
                    valid = 1'b1; read_valid = 1'b1;
                    aw_addr = 32'd2; w_data = 32'hFFFF_FFFF; w_strb = 4'hF; ar_addr = 32'd7;
                end
            end
            @(posedge ACLK); #1;
            lat++;
            valid = 1'b0; read_valid = 1'b0;
        end
        check({tag, " latency"}, 32'(lat), 32'd4);
        @(posedge ACLK); #1;
        check({tag, " ready pulse"}, {31'h0, ready}, 32'h0);
        check({tag, " busy after"}, {31'h0, busy}, 32'h0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        start_req(1'b1, 1'b0, addr, data, strb, 32'h0);
        wait_done("wr", 1'b0);
        model_write(addr, data, strb);
        check("wr resp", {30'h0, resp}, {30'h0, resp_m});
    endtask

    task automatic do_read(input logic [31:0] addr);
        start_req(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, addr);
        wait_done("rd", 1'b0);
        model_read(addr);
        check("rd data", rd_data, rd_data_m);
        check("rd resp", {30'h0, resp}, {30'h0, resp_m});
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge ACLK); #1;
            if (ready === 1'b1) seen++;
        end
        check({tag, " extra ready"}, 32'(seen), 32'd0);
    endtask

    // Protocol monitor: VALIDs held until handshake, READY pulses last one cycle
    logic p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;
    initial begin
        {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = 10'h0;
        forever begin
            @(negedge ACLK);
            if (ARESET !== 1'b1) begin
                {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = 10'h0;
            end else begin
                if (p_awv && !p_awr) check("awvalid held", {31'h0, dut.aw_valid_s}, 32'h1);
                if (p_wv && !p_wr)   check("wvalid held", {31'h0, dut.w_valid_s}, 32'h1);
                if (p_bv && !p_br)   check("bvalid held", {31'h0, dut.b_valid_s}, 32'h1);
                if (p_arv && !p_arr) check("arvalid held", {31'h0, dut.ar_valid_s}, 32'h1);
                if (p_rv && !p_rr)   check("rvalid held", {31'h0, dut.r_valid_s}, 32'h1);
                if (p_awr) check("awready pulse", {31'h0, dut.aw_ready_s}, 32'h0);
                if (p_wr)  check("wready pulse", {31'h0, dut.w_ready_s}, 32'h0);
                if (p_arr) check("arready pulse", {31'h0, dut.ar_ready_s}, 32'h0);
                p_awv = dut.aw_valid_s; p_awr = dut.aw_ready_s;
                p_wv  = dut.w_valid_s;  p_wr  = dut.w_ready_s;
                p_bv  = dut.b_valid_s;  p_br  = dut.b_ready_s;
                p_arv = dut.ar_valid_s; p_arr = dut.ar_ready_s;
                p_rv  = dut.r_valid_s;  p_rr  = dut.r_ready_s;
            end
        end
    end

    initial begin
        ARESET = 1'b0; valid = 1'b0; read_valid = 1'b0;
        aw_addr = 32'h0; w_data = 32'h0; w_strb = 4'h0; ar_addr = 32'h0;
        model_reset();
        repeat (3) @(posedge ACLK);
        #1;
        check("rst ready", {31'h0, ready}, 32'h0);
        check("rst busy", {31'h0, busy}, 32'h0);
        check("rst rd_data", rd_data, 32'h0);
        check("rst resp", {30'h0, resp}, 32'h0);
        ARESET = 1'b1;

        do_write(32'd0, 32'h0000_0000, 4'b0000);
        do_read(32'd0);
        do_write(32'd1, 32'h1234_5678, 4'b0011);
        do_read(32'd1);
        do_write(32'd3, 32'h1234_5678, 4'b1101);
        do_read(32'd3);
        do_write(32'd7, 32'h1234_5678, 4'b1111);
        do_write(32'd8, 32'hDEAD_BEEF, 4'b1111);
        do_read(32'd7);
        do_read(32'd8);

        // Simultaneous strobes: the write wins, the read is dropped.
        start_req(1'b1, 1'b1, 32'd5, 32'hAABB_CCDD, 4'hF, 32'd7);
        wait_done("both", 1'b0);
        model_write(32'd5, 32'hAABB_CCDD, 4'hF);
        check("both resp", {30'h0, resp}, {30'h0, resp_m});
        check("both rd_data kept", rd_data, rd_data_m);
        expect_quiet("both", 6);
        do_read(32'd5);

        // Strobes while busy are ignored.
        start_req(1'b1, 1'b0, 32'd4, 32'h1111_2222, 4'hF, 32'h0);
        wait_done("poke", 1'b1);
        model_write(32'd4, 32'h1111_2222, 4'hF);
        expect_quiet("poke", 6);
        do_read(32'd2);
        do_read(32'd4);

        // Reset shortly after edge 2 of a write.
        start_req(1'b1, 1'b0, 32'd6, 32'hCAFE_F00D, 4'hF, 32'h0);
        @(posedge ACLK);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        #1;
        model_reset();
        check("abort ready", {31'h0, ready}, 32'h0);
        check("abort busy", {31'h0, busy}, 32'h0);
        check("abort rd_data", rd_data, 32'h0);
        check("abort resp", {30'h0, resp}, 32'h0);
        check("abort awvalid", {31'h0, dut.aw_valid_s}, 32'h0);
        check("abort awready", {31'h0, dut.aw_ready_s}, 32'h0);
        check("abort bvalid", {31'h0, dut.b_valid_s}, 32'h0);
        repeat (2) @(posedge ACLK);
        #3;
        ARESET = 1'b1;
        expect_quiet("abort", 6);
        do_read(32'd6);
        do_read(32'd7);
        do_write(32'd6, 32'h0BAD_CAFE, 4'hF);
        do_read(32'd6);

        // Randomized traffic including out-of-range addresses.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [3:0]  s;
            a = 32'($urandom_range(9, 0));
            d = $urandom();
            s = 4'($urandom_range(15, 0));
            if ($urandom_range(1, 0) == 1) do_write(a, d, s);
            else do_read(a);
        end
        for (int i = 0; i < DEPTH; i++) do_read(32'(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
